// File: rtl/door_motor_ctrl.sv
// Up/down door motor controller: edge-triggered button, pause/reverse, travel watchdog, latched fault.
// Optional macro OBSTRUCT_REVERSE_EN: obstruction during downward travel reverses the door.
module door_motor_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Ac,
    input  logic       Up_Max,
    input  logic       Dn_Max,
    input  logic       Obs,
    output logic       UP_M,
    output logic       Dn_M,
    output logic       Fault,
    output logic [2:0] state_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MV_UP = 3'd1,
        MV_DN = 3'd2,
        STOP  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic             last_dir_reg, last_dir_next;
    logic             ac_q_reg;
    logic             up_m_reg, dn_m_reg, fault_reg;
    logic             ac_rise;
    logic             both_lim;
    logic             obs_rev;

`ifdef OBSTRUCT_REVERSE_EN
    assign obs_rev = Obs;
`else
    logic obs_unused;
    assign obs_unused = Obs;
    assign obs_rev    = 1'b0;
`endif

    assign ac_rise  = Ac & ~ac_q_reg;
    assign both_lim = Up_Max & Dn_Max;

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        last_dir_next = last_dir_reg;
        case (state_reg)
            IDLE: begin
                if (ac_rise) begin
                    timer_next = '0;
                    if (both_lim)    state_next = FAULT;
                    else if (Up_Max) state_next = MV_DN;
                    else             state_next = MV_UP;
                end
            end
            MV_UP: begin
                if (both_lim)                     state_next = FAULT;
                else if (Up_Max)                  state_next = IDLE;
                else if (timer_reg == TIMER_LAST) state_next = FAULT;
                else if (ac_rise) begin
                    state_next    = STOP;
                    last_dir_next = DIR_UP;
                end else begin
                    timer_next = timer_reg + CNT_W'(1);
                end
            end
            MV_DN: begin
                if (both_lim)    state_next = FAULT;
                else if (Dn_Max) state_next = IDLE;
                else if (obs_rev) begin
                    state_next = MV_UP;
                    timer_next = '0;
                end
                else if (timer_reg == TIMER_LAST) state_next = FAULT;
                else if (ac_rise) begin
                    state_next    = STOP;
                    last_dir_next = DIR_DN;
                end else begin
                    timer_next = timer_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (both_lim) state_next = FAULT;
                else if (ac_rise) begin
                    timer_next = '0;
                    state_next = (last_dir_reg == DIR_UP) ? MV_DN : MV_UP;
                end
            end
            FAULT: begin
                if (ac_rise && (Up_Max ^ Dn_Max)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ac_q tracks Ac even during reset so a button held through reset is not seen as a fresh press.
    always_ff @(posedge CLK) begin
        ac_q_reg <= Ac;
        if (RST) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            last_dir_reg <= DIR_UP;
            up_m_reg     <= 1'b0;
            dn_m_reg     <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            last_dir_reg <= last_dir_next;
            up_m_reg     <= (state_next == MV_UP);
            dn_m_reg     <= (state_next == MV_DN);
            fault_reg    <= (state_next == FAULT);
        end
    end

    assign UP_M    = up_m_reg;
    assign Dn_M    = dn_m_reg;
    assign Fault   = fault_reg;
    assign state_o = state_reg;

endmodule

// File: tb/tb_door_motor_ctrl.sv
// Directed bench for door_motor_ctrl with TIMEOUT_CYCLES=16: vector table plus watchdog/reset sequences.
module tb_door_motor_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Ac = 1'b0;
    logic       Up_Max = 1'b0;
    logic       Dn_Max = 1'b0;
    logic       Obs = 1'b0;
    logic       UP_M, Dn_M, Fault;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    door_motor_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST), .Ac(Ac), .Up_Max(Up_Max), .Dn_Max(Dn_Max), .Obs(Obs),
        .UP_M(UP_M), .Dn_M(Dn_M), .Fault(Fault), .state_o(state_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst, ac, up, dn, obs;
        logic [2:0] es;
        string      name;
    } vec_t;

`ifdef OBSTRUCT_REVERSE_EN
    localparam logic [2:0] OBS_EXP = 3'd1;
`else
    localparam logic [2:0] OBS_EXP = 3'd2;
`endif

    task automatic step(input logic r, input logic a, input logic u, input logic d, input logic o);
        @(negedge CLK);
        RST = r; Ac = a; Up_Max = u; Dn_Max = d; Obs = o;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input string nm, input logic [2:0] es);
        logic eu, ed, ef;
        eu = (es == 3'd1);
        ed = (es == 3'd2);
        ef = (es == 3'd4);
        checks++;
        if (state_o !== es || UP_M !== eu || Dn_M !== ed || Fault !== ef) begin
            errors++;
            $display("FAIL %s: state=%0d up=%b dn=%b fault=%b, required state=%0d up=%b dn=%b fault=%b",
                     nm, state_o, UP_M, Dn_M, Fault, es, eu, ed, ef);
        end else begin
            $display("ok   %s: state=%0d up=%b dn=%b fault=%b", nm, state_o, UP_M, Dn_M, Fault);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    vec_t vecs[$];

    initial begin
        int n;
        //           rst   ac    up    dn    obs   state
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, "rst_held_ac_0"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, "rst_held_ac_1"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, "release_ac_high"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, "ac_still_high"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "ac_fall"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "at_bottom_idle"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, "bottom_rise_up"});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, "moving_up"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "reach_top"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, "top_rise_down"});
        for (int i = 0; i < 9; i++)
            vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, "ac_held_down"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, "down_ac_low"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, "pause_from_down"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, "stop_hold"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, "reverse_to_up"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "up_to_top"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, "start_down"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, OBS_EXP, "obstruction"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, "both_limits_moving"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, "fault_rise_both"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, "fault_quiet"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, "fault_rise_none"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, "fault_quiet2"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "fault_exit_top"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "idle_quiet"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, "idle_both_limits"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, "fault_no_rise"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "fault_exit_top2"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "idle_quiet2"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, "mid_powerup_up"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, "up_ignores_dn_max"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "up_to_top2"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, "mid_up_again"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, "moving_up2"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, "pause_from_up"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, "stop_hold2"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, "reverse_to_down"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "down_to_bottom"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, "bottom_up3"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, "moving_up3"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, "pause3"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4, "stop_both_limits"});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, "fault_exit_bottom"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, "idle_final"});

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ac, vecs[i].up, vecs[i].dn, vecs[i].obs);
            check_state(vecs[i].name, vecs[i].es);
        end

        // Watchdog: unobstructed upward travel must run exactly 16 cycles then latch FAULT.
        n = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        while (UP_M === 1'b1 && n < 40) begin
            n++;
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_int("timeout_up_cycles", n, 16);
        check_state("timeout_fault", 3'd4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("fault_latched", 3'd4);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check_state("fault_exit_dn", 3'd0);

        // Reset mid-travel at timer=7, then a fresh run must again last the full 16 cycles.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_state("rst_seq_start", 3'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_state("rst_seq_timer7", 3'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_state("rst_aborts_travel", 3'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_state("after_rst_idle", 3'd0);
        n = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        while (UP_M === 1'b1 && n < 40) begin
            n++;
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        check_int("timer_restart_cycles", n, 16);
        check_state("timer_restart_fault", 3'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
